// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the register-access AXI initiator:
//   - reg_state_e : controller state encoding
//   - RESP_*      : AXI response codes carried on bresp/rresp
//   - AXI_SIZE_4B : burst size code for a 32-bit beat
//   - resp_is_err : any response other than OKAY is reported as an error
// -----------------------------------------------------------------------------
package axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } reg_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_ifc.sv
// -----------------------------------------------------------------------------
// axi_ifc
// Single-beat AXI4 subset with 32-bit address and data.
//   master modport : drives aw*/w*/ar* payload and valids, bready, rready
//   slave  modport : drives awready, wready, bresp/bvalid, arready,
//                    rdata/rresp/rvalid
// -----------------------------------------------------------------------------
interface axi_ifc;

  // write address
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  // write data
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // write response
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  // read address
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  // read data
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awlen, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_reg_master.sv
// -----------------------------------------------------------------------------
// axi_reg_master
// Turns a simple register command (index, read/write, data) into exactly one
// single-beat AXI transaction and returns the result as a response beat.
// Only one transaction is ever outstanding.
//
// Parameters
//   R_ADDR_WIDTH : width of the register index
//   BASE_ADDR    : byte address of register 0; register n is at BASE_ADDR+4n
// Ports
//   clk, rstn    : clock and synchronous active-low reset
//   m            : AXI initiator port
//   i_cmd_*      : command channel (valid/ready), o_cmd_ready high only in IDLE
//   o_rsp_*      : response channel (valid/ready); rdata is 0 for writes,
//                  resp is the captured bresp/rresp, err flags resp != OKAY
// -----------------------------------------------------------------------------
module axi_reg_master
  import axi_pkg::*;
#(
  parameter int unsigned R_ADDR_WIDTH = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic                    clk,
  input  logic                    rstn,
  axi_ifc.master                  m,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [R_ADDR_WIDTH-1:0] i_cmd_reg,
  input  logic [31:0]             i_cmd_wdata,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [31:0]             o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_rsp_err
);

  reg_state_e state;

  function automatic logic [31:0] reg_addr(input logic [R_ADDR_WIDTH-1:0] idx);
    return BASE_ADDR + 32'({idx, 2'b00});
  endfunction

  // Every access is one full-width beat.
  assign m.awlen  = 8'd0;
  assign m.awsize = AXI_SIZE_4B;
  assign m.wstrb  = 4'hF;
  assign m.wlast  = 1'b1;
  assign m.arlen  = 8'd0;
  assign m.arsize = AXI_SIZE_4B;

  // NOTE: synchronous reset -- rstn is only looked at on the rising clock
  // edge, so it is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      o_cmd_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_resp  <= RESP_OKAY;
      o_rsp_err   <= 1'b0;
      m.awaddr    <= '0;
      m.awvalid   <= 1'b0;
      m.wdata     <= '0;
      m.wvalid    <= 1'b0;
      m.bready    <= 1'b0;
      m.araddr    <= '0;
      m.arvalid   <= 1'b0;
      m.rready    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout -- every branch reads the
      // pre-edge values of the valids, so the two write handshakes can be
      // evaluated independently in the same cycle.
      unique case (state)
        IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready <= 1'b0;
            if (i_cmd_write) begin
              m.awaddr  <= reg_addr(i_cmd_reg);
              m.wdata   <= i_cmd_wdata;
              m.awvalid <= 1'b1;
              m.wvalid  <= 1'b1;
              state     <= WR_AW_W;
            end else begin
              m.araddr  <= reg_addr(i_cmd_reg);
              m.arvalid <= 1'b1;
              state     <= RD_AR;
            end
          end else begin
            o_cmd_ready <= 1'b1;
          end
        end

        WR_AW_W: begin
          // Each channel retires on its own handshake; the state moves on
          // once neither channel still has a pending valid.
          if (m.awvalid && m.awready) m.awvalid <= 1'b0;
          if (m.wvalid && m.wready)   m.wvalid  <= 1'b0;
          if ((!m.awvalid || m.awready) && (!m.wvalid || m.wready)) begin
            m.bready <= 1'b1;
            state    <= WR_B;
          end
        end

        WR_B: begin
          if (m.bvalid) begin
            m.bready    <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= '0;
            o_rsp_resp  <= m.bresp;
            o_rsp_err   <= resp_is_err(m.bresp);
            state       <= RSP;
          end
        end

        RD_AR: begin
          if (m.arready) begin
            m.arvalid <= 1'b0;
            m.rready  <= 1'b1;
            state     <= RD_R;
          end
        end

        RD_R: begin
          // rlast is not needed: every read is a single beat.
          if (m.rvalid) begin
            m.rready    <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= m.rdata;
            o_rsp_resp  <= m.rresp;
            o_rsp_err   <= resp_is_err(m.rresp);
            state       <= RSP;
          end
        end

        RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_reg_master.sv
// -----------------------------------------------------------------------------
// tb_axi_reg_master
// Directed bench for axi_reg_master. A small AXI slave with per-channel wait
// knobs answers the DUT; stimulus is applied and outputs are sampled on the
// falling clock edge, so one step() equals one DUT rising edge.
// -----------------------------------------------------------------------------
module tb_axi_reg_master;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_reg = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  axi_ifc axi ();

  axi_reg_master #(
    .R_ADDR_WIDTH(2),
    .BASE_ADDR   (32'h0)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .m          (axi),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_write(cmd_write),
    .i_cmd_reg  (cmd_reg),
    .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_resp (rsp_resp),
    .o_rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Slave model: each ready/valid is withheld for <chan>_delay cycles after
  // the master starts waiting on it. b/r follow their address handshake.
  // ---------------------------------------------------------------------------
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = RESP_OKAY;
  logic [1:0]  rresp_cfg = RESP_OKAY;
  logic [31:0] rdata_cfg = '0;

  int   aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic aw_got, w_got, b_pend, r_pend;

  wire aw_hs = axi.awvalid && axi.awready;
  wire w_hs  = axi.wvalid && axi.wready;
  wire b_hs  = axi.bvalid && axi.bready;
  wire ar_hs = axi.arvalid && axi.arready;
  wire r_hs  = axi.rvalid && axi.rready;

  assign axi.awready = axi.awvalid && (aw_wait >= aw_delay);
  assign axi.wready  = axi.wvalid && (w_wait >= w_delay);
  assign axi.bvalid  = b_pend && (b_wait >= b_delay);
  assign axi.bresp   = bresp_cfg;
  assign axi.arready = axi.arvalid && (ar_wait >= ar_delay);
  assign axi.rvalid  = r_pend && (r_wait >= r_delay);
  assign axi.rresp   = rresp_cfg;
  assign axi.rdata   = rdata_cfg;

  always @(posedge clk) begin
    if (!rstn) begin
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      aw_got  <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_wait <= (axi.awvalid && !axi.awready) ? aw_wait + 1 : 0;
      w_wait  <= (axi.wvalid && !axi.wready) ? w_wait + 1 : 0;
      ar_wait <= (axi.arvalid && !axi.arready) ? ar_wait + 1 : 0;

      if (aw_hs) aw_got <= 1'b1;
      if (w_hs)  w_got  <= 1'b1;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        b_pend <= 1'b1;
        b_wait <= 0;
      end else if (b_pend && !axi.bvalid) begin
        b_wait <= b_wait + 1;
      end
      if (b_hs) b_pend <= 1'b0;

      if (ar_hs) begin
        r_pend <= 1'b1;
        r_wait <= 0;
      end else if (r_pend && !axi.rvalid) begin
        r_wait <= r_wait + 1;
      end
      if (r_hs) r_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one command while the DUT is idle; returns just after the accept edge.
  task automatic send(input string tag, input logic wr, input logic [1:0] idx,
                      input logic [31:0] data);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_reg   = idx;
    cmd_wdata = data;
    step();
    cmd_valid = 1'b0;
    check({tag, "_cmd_ready_low"}, 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    check({tag, "_rsp_arrived"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_consumed"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    step();
    step();
    check("rst_ctrl", {25'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                       axi.rready, rsp_valid, cmd_ready}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_resp", {29'd0, rsp_err, rsp_resp}, 32'd0);
    check("rst_awaddr", axi.awaddr, 32'd0);
    check("rst_araddr", axi.araddr, 32'd0);
    check("rst_wdata", axi.wdata, 32'd0);
    rstn = 1'b1;
    step();
    check("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write: accept edge, handshake edge, response edge.
    send("t1", 1'b1, 2'd1, 32'hDEADBEEF);
    check("t1_aw_w_valid", {30'd0, axi.awvalid, axi.wvalid}, 32'b11);
    check("t1_awaddr", axi.awaddr, 32'h4);
    check("t1_wdata", axi.wdata, 32'hDEADBEEF);
    check("t1_wlast_wstrb", {27'd0, axi.wlast, axi.wstrb}, 32'h1F);
    check("t1_awlen_size", {21'd0, axi.awlen, axi.awsize}, {21'd0, 8'd0, 3'b010});
    check("t1_rsp_not_yet", 32'(rsp_valid), 32'd0);
    step();
    check("t1_bready_only", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'b001);
    check("t1_rsp_not_yet2", 32'(rsp_valid), 32'd0);
    step();
    check("t1_rsp_valid", {30'd0, rsp_valid, axi.bready}, 32'b10);
    check("t1_rsp_resp_err", {29'd0, rsp_err, rsp_resp}, 32'd0);
    check("t1_rsp_rdata", rsp_rdata, 32'd0);
    consume("t1");

    // Read reg 3 with rvalid withheld for five cycles.
    r_delay   = 5;
    rdata_cfg = 32'h12345678;
    send("t2", 1'b0, 2'd3, 32'd0);
    check("t2_arvalid", {30'd0, axi.arvalid, axi.rready}, 32'b10);
    check("t2_araddr", axi.araddr, 32'hC);
    check("t2_arlen_size", {21'd0, axi.arlen, axi.arsize}, {21'd0, 8'd0, 3'b010});
    step();
    for (int i = 0; i < 5; i++) begin
      check("t2_rready_hold", {29'd0, axi.arvalid, axi.rready, rsp_valid}, 32'b010);
      step();
    end
    step();
    check("t2_rsp_valid", {30'd0, rsp_valid, axi.rready}, 32'b10);
    check("t2_rdata", rsp_rdata, 32'h12345678);
    check("t2_resp_err", {29'd0, rsp_err, rsp_resp}, 32'd0);
    consume("t2");
    r_delay = 0;

    // Write: wready immediately, awready two cycles later.
    aw_delay = 2;
    send("t3", 1'b1, 2'd2, 32'hA5A50001);
    check("t3_aw_w_valid", {30'd0, axi.awvalid, axi.wvalid}, 32'b11);
    step();
    check("t3_w_done", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'b100);
    check("t3_awaddr_stable1", axi.awaddr, 32'h8);
    step();
    check("t3_aw_waiting", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'b100);
    check("t3_awaddr_stable2", axi.awaddr, 32'h8);
    step();
    check("t3_both_done", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'b001);
    step();
    check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t3_rdata_zero", rsp_rdata, 32'd0);
    check("t3_resp_err", {29'd0, rsp_err, rsp_resp}, 32'd0);
    consume("t3");
    aw_delay = 0;

    // Write: awready immediately, wready three cycles later, DECERR response.
    w_delay   = 3;
    bresp_cfg = RESP_DECERR;
    send("t4", 1'b1, 2'd0, 32'h0BADF00D);
    check("t4_aw_w_valid", {30'd0, axi.awvalid, axi.wvalid}, 32'b11);
    check("t4_awaddr", axi.awaddr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_w_waiting", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'b010);
      check("t4_wdata_stable", axi.wdata, 32'h0BADF00D);
    end
    step();
    check("t4_both_done", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'b001);
    step();
    check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t4_resp_err", {29'd0, rsp_err, rsp_resp}, {29'd0, 1'b1, 2'd3});
    check("t4_rdata_zero", rsp_rdata, 32'd0);
    consume("t4");
    w_delay   = 0;
    bresp_cfg = RESP_OKAY;

    // Read with SLVERR.
    ar_delay  = 1;
    rresp_cfg = RESP_SLVERR;
    rdata_cfg = 32'hCAFE0000;
    send("t5", 1'b0, 2'd0, 32'd0);
    check("t5_araddr", axi.araddr, 32'h0);
    wait_rsp("t5");
    check("t5_resp_err", {29'd0, rsp_err, rsp_resp}, {29'd0, 1'b1, 2'd2});
    check("t5_rdata", rsp_rdata, 32'hCAFE0000);
    consume("t5");
    ar_delay  = 0;
    rresp_cfg = RESP_OKAY;

    // Response held by a slow sink; next command waits for consumption.
    rdata_cfg = 32'h00001041;
    send("t6", 1'b1, 2'd2, 32'h00000041);
    wait_rsp("t6");
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_hold_ctrl", {30'd0, rsp_valid, cmd_ready}, 32'b10);
      check("t6_hold_data", {29'd0, rsp_err, rsp_resp}, 32'd0);
      check("t6_hold_rdata", rsp_rdata, 32'd0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_reg   = 2'd1;
    step();
    rsp_ready = 1'b0;
    check("t6_consumed", {29'd0, rsp_valid, cmd_ready, axi.arvalid}, 32'b010);
    step();
    cmd_valid = 1'b0;
    check("t6_next_accepted", {30'd0, cmd_ready, axi.arvalid}, 32'b01);
    check("t6_next_araddr", axi.araddr, 32'h4);
    wait_rsp("t6b");
    check("t6b_rdata", rsp_rdata, 32'h00001041);
    consume("t6b");

    // Reset while waiting in WR_B abandons the write.
    b_delay = 10;
    send("t7", 1'b1, 2'd3, 32'h00000042);
    step();
    check("t7_in_wr_b", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'b001);
    rstn = 1'b0;
    step();
    check("t7_rst_ctrl", {25'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                          axi.rready, rsp_valid, cmd_ready}, 32'd0);
    check("t7_rst_rdata", rsp_rdata, 32'd0);
    check("t7_rst_awaddr", axi.awaddr, 32'd0);
    check("t7_rst_wdata", axi.wdata, 32'd0);
    rstn    = 1'b1;
    b_delay = 0;
    step();
    check("t7_release", {30'd0, rsp_valid, cmd_ready}, 32'b01);
    for (int i = 0; i < 12; i++) begin
      step();
      check("t7_no_rsp", {30'd0, rsp_valid, axi.bready}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
